pipe_ctrl: RTL and testbench

Hazard and sequencing controller for the four pipeline buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register. It detects load-use hazards, taken branches, multi-cycle data-memory waits and halt. From these it drives per-buffer `pause` (active-high hold) and `bubble` (active-low clear) lines. It also keeps saturating stall and flush counters for performance readout.

---
 rtl/pipe_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard/sequencing controller driving pause/bubble lines for the
// IF/ID, ID/EX, EX/MEM, MEM/WB buffers and the PC, with saturating perf counters.
module pipe_ctrl #(
   parameter int RA         = 4,
   parameter int LOAD_STALL = 2,
   parameter int CW         = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [RA-1:0] id_rs1,
   input  logic [RA-1:0] id_rs2,
   input  logic          id_use1,
   input  logic          id_use2,
   input  logic [RA-1:0] ex_rd,
   input  logic          ex_mem_read,
   input  logic          ex_reg_write,
   input  logic          ex_branch_taken,
   input  logic          mem_busy,
   input  logic          halt,
   output logic          pause_pc,
   output logic          pause_ifid,
   output logic          pause_idex,
   output logic          pause_exmem,
   output logic          pause_memwb,
   output logic          bubble_ifid,
   output logic          bubble_idex,
   output logic          bubble_exmem,
   output logic          halted,
   output logic [CW-1:0] stall_cycles,
   output logic [CW-1:0] flush_count
);

   localparam logic [2:0] RUN    = 3'd0;
   localparam logic [2:0] LSTALL = 3'd1;
   localparam logic [2:0] FLUSH  = 3'd2;
   localparam logic [2:0] MWAIT  = 3'd3;
   localparam logic [2:0] HALT   = 3'd4;

   localparam int SW = (LOAD_STALL > 1) ? $clog2(LOAD_STALL) : 1;
   localparam logic [SW-1:0] STALL_LOAD = SW'(LOAD_STALL - 1);
   localparam logic [CW-1:0] CNT_MAX    = '1;

   logic [2:0]    state, state_nxt;
   logic [SW-1:0] cnt, cnt_nxt;
   logic          lu;
   logic          hold_front, hold_all, kill_front, kill_idex;
   logic          inc_stall, inc_flush;

   assign lu = ex_mem_read && ex_reg_write && (ex_rd != '0) &&
               (((ex_rd == id_rs1) && id_use1) || ((ex_rd == id_rs2) && id_use2));

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      hold_front = 1'b0;
      hold_all   = 1'b0;
      kill_front = 1'b0;
      kill_idex  = 1'b0;
      inc_stall  = 1'b0;
      inc_flush  = 1'b0;
      case (state)
         LSTALL: begin
            inc_stall = 1'b1;
            if (mem_busy) begin
               hold_all = 1'b1;
            end else begin
               hold_front = 1'b1;
               cnt_nxt    = cnt - 1'b1;
               if (cnt_nxt == '0) state_nxt = RUN;
            end
         end
         FLUSH: begin
            if (mem_busy) begin
               hold_all  = 1'b1;
               inc_stall = 1'b1;
               state_nxt = MWAIT;
            end else begin
               state_nxt = RUN;
            end
         end
         HALT: hold_all = 1'b1;
         default: begin
            // RUN, and also MWAIT: while busy it matches RUN's busy arm, and the
            // cycle busy falls must already be evaluated as RUN.
            if (mem_busy) begin
               hold_all  = 1'b1;
               inc_stall = 1'b1;
               state_nxt = MWAIT;
            end else if (ex_branch_taken) begin
               kill_front = 1'b1;
               kill_idex  = 1'b1;
               inc_flush  = 1'b1;
               state_nxt  = FLUSH;
            end else if (halt) begin
               hold_all  = 1'b1;
               state_nxt = HALT;
            end else if (lu) begin
               hold_front = 1'b1;
               kill_idex  = 1'b1;
               inc_stall  = 1'b1;
               cnt_nxt    = STALL_LOAD;
               state_nxt  = (LOAD_STALL > 1) ? LSTALL : RUN;
            end else begin
               state_nxt = RUN;
            end
         end
      endcase
   end

   // Outputs are forced idle while reset is low regardless of inputs.
   assign pause_pc     = rst & (hold_all | hold_front);
   assign pause_ifid   = rst & (hold_all | hold_front);
   assign pause_idex   = rst & hold_all;
   assign pause_exmem  = rst & hold_all;
   assign pause_memwb  = rst & hold_all;
   assign bubble_ifid  = ~(rst & kill_front);
   assign bubble_idex  = ~(rst & kill_idex);
   assign bubble_exmem = 1'b1;
   assign halted       = (state == HALT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= RUN;
         cnt          <= '0;
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (inc_stall && (stall_cycles != CNT_MAX)) stall_cycles <= stall_cycles + 1'b1;
         if (inc_flush && (flush_count != CNT_MAX)) flush_count <= flush_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// against a behavioural model of the hazard rules.
module tb_pipe_ctrl;
   localparam int RA = 4;
   localparam int LS = 2;
   localparam int CW = 16;

   // {pause_pc, pause_ifid, pause_idex, pause_exmem, pause_memwb,
   //  bubble_ifid, bubble_idex, bubble_exmem, halted}
   localparam logic [8:0] F_NONE = 9'b00000_111_0;
   localparam logic [8:0] F_ALL  = 9'b11111_111_0;
   localparam logic [8:0] F_LU   = 9'b11000_101_0;
   localparam logic [8:0] F_HOLD = 9'b11000_111_0;
   localparam logic [8:0] F_BR   = 9'b00000_001_0;
   localparam logic [8:0] F_HALT = 9'b11111_111_1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [RA-1:0] id_rs1, id_rs2, ex_rd;
   logic          id_use1, id_use2, ex_mem_read, ex_reg_write;
   logic          ex_branch_taken, mem_busy, halt;
   logic [8:0]    flags, s_flags;
   logic [CW-1:0] stall_cycles, flush_count;
   logic [3:0]    s_stall, s_flush;
   int            n_cmp = 0;
   int            n_err = 0;

   // behavioural model state
   int m_hold, m_stall, m_fl, n_hold;
   bit m_flush, m_wait, m_halt, n_flush, n_wait, n_halt, inc_s, inc_f;
   logic [8:0] e_flags;

   always #5 clk = ~clk;

   pipe_ctrl #(.RA(RA), .LOAD_STALL(LS), .CW(CW)) dut (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1),
      .id_use2(id_use2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
      .ex_reg_write(ex_reg_write), .ex_branch_taken(ex_branch_taken),
      .mem_busy(mem_busy), .halt(halt),
      .pause_pc(flags[8]), .pause_ifid(flags[7]), .pause_idex(flags[6]),
      .pause_exmem(flags[5]), .pause_memwb(flags[4]), .bubble_ifid(flags[3]),
      .bubble_idex(flags[2]), .bubble_exmem(flags[1]), .halted(flags[0]),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   pipe_ctrl #(.RA(RA), .LOAD_STALL(LS), .CW(4)) dut_sat (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1),
      .id_use2(id_use2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
      .ex_reg_write(ex_reg_write), .ex_branch_taken(ex_branch_taken),
      .mem_busy(mem_busy), .halt(halt),
      .pause_pc(s_flags[8]), .pause_ifid(s_flags[7]), .pause_idex(s_flags[6]),
      .pause_exmem(s_flags[5]), .pause_memwb(s_flags[4]), .bubble_ifid(s_flags[3]),
      .bubble_idex(s_flags[2]), .bubble_exmem(s_flags[1]), .halted(s_flags[0]),
      .stall_cycles(s_stall), .flush_count(s_flush)
   );

   task automatic set_idle();
      id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
      id_use1 = 1'b0; id_use2 = 1'b0; ex_mem_read = 1'b0; ex_reg_write = 1'b0;
      ex_branch_taken = 1'b0; mem_busy = 1'b0; halt = 1'b0;
   endtask

   task automatic set_lu();
      ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 4'd3;
      id_rs1 = 4'd5; id_use1 = 1'b1; id_rs2 = 4'd3; id_use2 = 1'b1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Expected outputs and next model state from the hazard rules for the current inputs.
   task automatic model_eval();
      bit lu_m, run;
      lu_m = ex_mem_read && ex_reg_write && (ex_rd != 0) &&
             ((ex_rd == id_rs1 && id_use1) || (ex_rd == id_rs2 && id_use2));
      n_hold = m_hold; n_flush = 0; n_wait = 0; n_halt = m_halt;
      inc_s = 0; inc_f = 0; run = 0; e_flags = F_NONE;
      if (!rst) e_flags = F_NONE;
      else if (m_halt) e_flags = F_HALT;
      else if (m_hold > 0) begin
         inc_s = 1;
         if (mem_busy) e_flags = F_ALL;
         else begin e_flags = F_HOLD; n_hold = m_hold - 1; end
      end else if (m_flush) begin
         if (mem_busy) begin e_flags = F_ALL; inc_s = 1; n_wait = 1; end
      end else if (m_wait && mem_busy) begin
         e_flags = F_ALL; inc_s = 1; n_wait = 1;
      end else run = 1;
      if (run) begin
         if (mem_busy) begin e_flags = F_ALL; inc_s = 1; n_wait = 1; end
         else if (ex_branch_taken) begin e_flags = F_BR; inc_f = 1; n_flush = 1; end
         else if (halt) begin e_flags = F_ALL; n_halt = 1; end
         else if (lu_m) begin e_flags = F_LU; inc_s = 1; n_hold = LS - 1; end
      end
   endtask

   task automatic model_commit();
      if (!rst) begin
         m_hold = 0; m_flush = 0; m_wait = 0; m_halt = 0; m_stall = 0; m_fl = 0;
      end else begin
         m_hold = n_hold; m_flush = n_flush; m_wait = n_wait; m_halt = n_halt;
         if (inc_s && m_stall < (1 << CW) - 1) m_stall++;
         if (inc_f && m_fl < (1 << CW) - 1) m_fl++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         id_rs1 = RA'($urandom); id_rs2 = RA'($urandom); ex_rd = RA'($urandom);
         id_use1 = 1'($urandom); id_use2 = 1'($urandom); ex_mem_read = 1'($urandom);
         ex_reg_write = 1'($urandom); ex_branch_taken = 1'($urandom);
         mem_busy = 1'($urandom); halt = 1'($urandom);
         #3;
         n_cmp++;
         if (flags !== F_NONE || s_flags !== F_NONE || stall_cycles !== '0 || flush_count !== '0) begin
            n_err++;
            $display("FAIL reset_values i=%0d flags=%b sflags=%b stall=%0d flush=%0d expected flags=%b counters 0",
                     i, flags, s_flags, stall_cycles, flush_count, F_NONE);
         end
      end
      @(posedge clk); #1;
      rst = 1'b1;
      set_idle();
      @(negedge clk);
      n_cmp++;
      if (flags !== F_NONE) begin
         n_err++;
         $display("FAIL reset_release flags=%b expected %b", flags, F_NONE);
      end
      next_cycle();
      // RUN must react to a load-use hazard immediately after release
      set_lu();
      @(negedge clk);
      n_cmp++;
      if (flags !== F_LU) begin
         n_err++;
         $display("FAIL reset_run_state flags=%b expected %b", flags, F_LU);
      end
      next_cycle();
      set_idle();
      next_cycle();
   endtask

   task automatic test_load_use();
      logic [8:0] exp;
      int base;
      bit stalls;
      for (int v = 0; v < 5; v++) begin
         base = int'(stall_cycles);
         stalls = (v == 0 || v == 3);
         for (int c = 0; c < 3; c++) begin
            set_idle();
            if (c < 2) begin
               ex_mem_read = (v != 4); ex_reg_write = 1'b1;
               case (v)
                  0: begin ex_rd = 4'd3; id_rs1 = 4'd5; id_use1 = 1'b1; id_rs2 = 4'd3; id_use2 = 1'b1; end
                  1: begin ex_rd = 4'd0; id_rs1 = 4'd0; id_use1 = 1'b1; id_rs2 = 4'd0; id_use2 = 1'b1; end
                  2: begin ex_rd = 4'd3; id_rs1 = 4'd5; id_use1 = 1'b1; id_rs2 = 4'd3; id_use2 = 1'b0; end
                  3: begin ex_rd = 4'd5; id_rs1 = 4'd5; id_use1 = 1'b1; id_rs2 = 4'd3; id_use2 = 1'b0; end
                  default: begin ex_rd = 4'd3; id_rs1 = 4'd3; id_use1 = 1'b1; id_rs2 = 4'd3; id_use2 = 1'b1; end
               endcase
            end
            exp = !stalls ? F_NONE : (c == 0) ? F_LU : (c == 1) ? F_HOLD : F_NONE;
            @(negedge clk);
            n_cmp++;
            if (flags !== exp) begin
               n_err++;
               $display("FAIL load_use v=%0d c=%0d flags=%b expected %b", v, c, flags, exp);
            end
            if (c == 2) begin
               n_cmp++;
               if (stall_cycles !== CW'(base + (stalls ? 2 : 0))) begin
                  n_err++;
                  $display("FAIL load_use_stall_cycles v=%0d got %0d expected %0d",
                           v, stall_cycles, base + (stalls ? 2 : 0));
               end
            end
            next_cycle();
         end
      end
   endtask

   task automatic test_branch();
      logic [8:0] exp [5];
      int base;
      exp = '{F_BR, F_NONE, F_LU, F_HOLD, F_NONE};
      base = int'(flush_count);
      for (int c = 0; c < 5; c++) begin
         set_idle();
         if (c == 0) ex_branch_taken = 1'b1;
         if (c == 1 || c == 2) set_lu();
         @(negedge clk);
         n_cmp++;
         if (flags !== exp[c]) begin
            n_err++;
            $display("FAIL branch c=%0d flags=%b expected %b", c, flags, exp[c]);
         end
         if (c == 1) begin
            n_cmp++;
            if (flush_count !== CW'(base + 1)) begin
               n_err++;
               $display("FAIL branch_flush_count got %0d expected %0d", flush_count, base + 1);
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_mwait_in_lstall();
      logic [8:0] exp [6];
      int base, held;
      exp = '{F_LU, F_ALL, F_ALL, F_ALL, F_HOLD, F_NONE};
      base = int'(stall_cycles);
      held = 0;
      for (int c = 0; c < 6; c++) begin
         set_idle();
         if (c == 0) set_lu();
         if (c >= 1 && c <= 3) mem_busy = 1'b1;
         @(negedge clk);
         if (flags[8]) held++;
         n_cmp++;
         if (flags !== exp[c]) begin
            n_err++;
            $display("FAIL mwait_lstall c=%0d flags=%b expected %b", c, flags, exp[c]);
         end
         if (c == 5) begin
            n_cmp++;
            if (held != 5 || stall_cycles !== CW'(base + 5)) begin
               n_err++;
               $display("FAIL mwait_lstall_totals pc_hold=%0d stall=%0d expected 5 and %0d",
                        held, stall_cycles, base + 5);
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_priority();
      logic [8:0] exp [8];
      int base_f, stall_h;
      exp = '{F_ALL, F_ALL, F_ALL, F_BR, F_NONE, F_ALL, F_HALT, F_HALT};
      base_f = int'(flush_count);
      stall_h = 0;
      for (int c = 0; c < 8; c++) begin
         set_idle();
         if (c <= 2) mem_busy = 1'b1;
         if (c <= 3) ex_branch_taken = 1'b1;
         if (c <= 5) halt = 1'b1;
         if (c == 7) begin set_lu(); mem_busy = 1'b1; ex_branch_taken = 1'b1; end
         @(negedge clk);
         n_cmp++;
         if (flags !== exp[c]) begin
            n_err++;
            $display("FAIL priority c=%0d flags=%b expected %b", c, flags, exp[c]);
         end
         if (c == 5) stall_h = int'(stall_cycles);
         if (c == 7) begin
            n_cmp++;
            if (flush_count !== CW'(base_f + 1) || stall_cycles !== CW'(stall_h)) begin
               n_err++;
               $display("FAIL priority_counters flush=%0d stall=%0d expected %0d and %0d",
                        flush_count, stall_cycles, base_f + 1, stall_h);
            end
         end
         if (c < 7) next_cycle();
      end
      #2;
      rst = 1'b0;
      #1;
      n_cmp++;
      if (flags !== F_NONE || stall_cycles !== '0 || flush_count !== '0) begin
         n_err++;
         $display("FAIL halt_reset flags=%b stall=%0d flush=%0d expected %b and 0",
                  flags, stall_cycles, flush_count, F_NONE);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      set_idle();
      @(negedge clk);
      n_cmp++;
      if (flags !== F_NONE) begin
         n_err++;
         $display("FAIL halt_reset_release flags=%b expected %b", flags, F_NONE);
      end
      next_cycle();
   endtask

   task automatic test_saturation();
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < (r == 0 ? 20 : 3); k++) begin
            set_idle();
            ex_branch_taken = 1'b1;
            next_cycle();
            set_idle();
            next_cycle();
         end
         @(negedge clk);
         n_cmp++;
         if (s_flush !== 4'd15 || flush_count !== CW'(r == 0 ? 20 : 23)) begin
            n_err++;
            $display("FAIL saturation r=%0d sat_flush=%0d flush=%0d expected 15 and %0d",
                     r, s_flush, flush_count, (r == 0 ? 20 : 23));
         end
         next_cycle();
      end
   endtask

   task automatic test_random();
      rst = 1'b0;
      set_idle();
      model_eval();
      next_cycle();
      model_commit();
      rst = 1'b1;
      for (int i = 0; i < 600; i++) begin
         rst = !((m_halt && $urandom_range(0, 2) == 0) || $urandom_range(0, 99) == 0);
         ex_rd = RA'($urandom_range(0, 3));
         id_rs1 = RA'($urandom_range(0, 3));
         id_rs2 = RA'($urandom_range(0, 3));
         id_use1 = 1'($urandom); id_use2 = 1'($urandom);
         ex_mem_read = ($urandom_range(0, 9) < 7);
         ex_reg_write = ($urandom_range(0, 9) < 7);
         mem_busy = ($urandom_range(0, 3) == 0);
         ex_branch_taken = (m_hold == 0 && !m_flush && $urandom_range(0, 9) == 0);
         halt = ($urandom_range(0, 49) == 0);
         @(negedge clk);
         model_eval();
         n_cmp++;
         if (flags !== e_flags || stall_cycles !== CW'(rst ? m_stall : 0) ||
             flush_count !== CW'(rst ? m_fl : 0)) begin
            n_err++;
            $display("FAIL random i=%0d flags=%b stall=%0d flush=%0d expected %b %0d %0d",
                     i, flags, stall_cycles, flush_count, e_flags,
                     rst ? m_stall : 0, rst ? m_fl : 0);
         end
         @(posedge clk);
         model_commit();
         #1;
      end
      rst = 1'b1;
      set_idle();
   endtask

   initial begin
      set_idle();
      test_reset();
      test_load_use();
      test_branch();
      test_mwait_in_lstall();
      test_priority();
      test_saturation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish within time limit");
      n_err++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "timeout");
   end
endmodule
